// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings presented on the op port
//   - controller state encodings
//   - iteration counter width helper
// -----------------------------------------------------------------------------
package mdu_pkg;

    // Operation encodings. Bit 1 selects divide, bit 0 selects unsigned.
    localparam logic [1:0] MDU_MULT  = 2'b00;
    localparam logic [1:0] MDU_MULTU = 2'b01;
    localparam logic [1:0] MDU_DIV   = 2'b10;
    localparam logic [1:0] MDU_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_RUN  = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int mdu_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = mdu_cnt_w(MDU_WIDTH);

endpackage

// File: rtl/mdu_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// One combinational iteration of the multiply/divide datapath. Operands are
// unsigned magnitudes; sign handling lives in the parent.
//
// The accumulator is 2*WIDTH bits: {upper, lower}.
//   Multiply (mode_i=0): shift-add. lower holds the remaining multiplier bits,
//     upper the running partial product. Add operand_i when acc_i[0] is set,
//     then shift the whole thing right one place (carry enters at the top).
//   Divide (mode_i=1): restoring division. upper holds the partial remainder,
//     lower the remaining dividend bits. Shift left one place and subtract
//     operand_i from the upper part; keep the difference if it did not borrow.
//     The new quotient bit is reported on q_bit_o; acc_o[0] is left 0 so the
//     parent can merge it.
//
// Ports:
//   mode_i     in   1          0 = multiply step, 1 = divide step
//   acc_i      in   2*WIDTH    current accumulator
//   operand_i  in   WIDTH      multiplicand (multiply) or divisor (divide)
//   acc_o      out  2*WIDTH    next accumulator
//   q_bit_o    out  1          quotient bit produced by a divide step
// -----------------------------------------------------------------------------
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic                 mode_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o,
    output logic                 q_bit_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = '0;
        diff    = '0;
        acc_o   = acc_i;
        q_bit_o = 1'b0;
        if (!mode_i) begin
            sum   = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
                  + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end else begin
            // acc_i[2W-1:W-1] is the upper half after the left shift.
            diff = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, operand_i};
            if (!diff[WIDTH]) begin
                acc_o   = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
                q_bit_o = 1'b1;
            end else begin
                acc_o   = {acc_i[2*WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit with architectural HI/LO registers.
// Implements MULT, MULTU, DIV, DIVU (started with start/op) and MTHI/MTLO
// (write_hi/write_lo, honoured only while idle and start is low).
//
// Handshake: start is sampled only in IDLE. busy is high from the edge after
// acceptance through the FIX edge (WIDTH+1 cycles); done pulses for the one
// cycle after FIX, when hi/lo already hold the new result. busy and done are
// never high together. Inputs are ignored while busy.
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      asynchronous active-high reset
//   op_a      in   WIDTH  rs operand / MTHI-MTLO data
//   op_b      in   WIDTH  rt operand
//   start     in   1      begin operation selected by op
//   op        in   2      MULT/MULTU/DIV/DIVU
//   write_hi  in   1      MTHI
//   write_lo  in   1      MTLO
//   hi        out  WIDTH  HI register (product high / remainder)
//   lo        out  WIDTH  LO register (product low / quotient)
//   busy      out  1      operation in progress
//   done      out  1      result-ready pulse
// -----------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             write_hi,
    input  logic             write_lo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = mdu_cnt_w(WIDTH);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic                 is_div_q, is_div_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    // Operand preparation at acceptance time.
    logic                 signed_op;
    logic                 in_sign_a;
    logic                 in_sign_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    assign signed_op = ~op[0];
    assign in_sign_a = signed_op & op_a[WIDTH-1];
    assign in_sign_b = signed_op & op_b[WIDTH-1];
    assign mag_a     = in_sign_a ? -op_a : op_a;
    assign mag_b     = in_sign_b ? -op_b : op_b;

    // Single datapath iteration.
    logic [2*WIDTH-1:0]   step_acc;
    logic                 step_q;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode_i    (is_div_q),
        .acc_i     (acc_q),
        .operand_i (opnd_q),
        .acc_o     (step_acc),
        .q_bit_o   (step_q)
    );

    // Sign correction applied on the FIX edge. Sign flags are only ever set
    // for signed operations, so no op check is needed here.
    logic                 neg_res;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;
    logic [WIDTH-1:0]     res_hi;
    logic [WIDTH-1:0]     res_lo;

    always_comb begin
        neg_res  = sign_a_q ^ sign_b_q;
        prod_fix = neg_res ? -acc_q : acc_q;
        quo_fix  = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        // Truncating division: remainder follows the dividend's sign.
        rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div_q) begin
            if (opnd_q == '0) begin
                // Divide by zero reports the dividend as originally given.
                res_hi = raw_a_q;
                res_lo = '1;
            end else begin
                res_hi = rem_fix;
                res_lo = quo_fix;
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        raw_a_d  = raw_a_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    // start wins over a same-cycle MTHI/MTLO.
                    acc_d    = {{WIDTH{1'b0}}, mag_a};
                    opnd_d   = mag_b;
                    raw_a_d  = op_a;
                    is_div_d = op[1];
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    cnt_d    = '0;
                    state_d  = MDU_RUN;
                end else begin
                    if (write_hi) hi_d = op_a;
                    if (write_lo) lo_d = op_a;
                end
            end
            MDU_RUN: begin
                acc_d = {step_acc[2*WIDTH-1:1],
                         is_div_q ? step_q : step_acc[0]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MDU_FIX;
                end
            end
            MDU_FIX: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= MDU_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            raw_a_q  <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            raw_a_q  <= raw_a_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != MDU_IDLE);
    assign done = done_q;

endmodule
